// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Keeps the fetch PC, runs a single-outstanding req/ack handshake to
// instruction memory, buffers returned words in a small prefetch FIFO and
// presents the FIFO head to the IF/ID register. Branches flush the FIFO and
// discard any fetch still in flight.

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Sequential state
  state_t            state_r;
  logic [31:0]       fetch_pc_r;
  logic              rom_req_r;
  logic [31:0]       rom_addr_r;
  logic [31:0]       pc_mem_r   [DEPTH];
  logic [31:0]       inst_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Combinational next-state / control
  state_t            state_nxt_s;
  logic [31:0]       fetch_pc_nxt_s;
  logic              rom_req_nxt_s;
  logic [31:0]       rom_addr_nxt_s;
  logic              head_valid_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              can_issue_s;

  // FIFO handshake: head visibility, push of accepted words, pop by downstream
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    out_valid_s  = head_valid_s && !branch_flag_i;
    pop_s        = out_valid_s && !stall;
    // A word is kept only when it answers a live request and no redirect
    // is happening in the same cycle.
    push_s       = (state_r == ST_WAIT) && rom_ack && !branch_flag_i;
  end

  // Occupancy after this edge; a new request needs a guaranteed free slot
  always_comb begin
    count_next_s = count_r;
    if (branch_flag_i) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        count_next_s = count_next_s + CNT_ONE;
      end else begin
        count_next_s = count_next_s;
      end
      if (pop_s) begin
        count_next_s = count_next_s - CNT_ONE;
      end else begin
        count_next_s = count_next_s;
      end
    end
    can_issue_s = (count_next_s < DEPTH_C);
  end

  // Fetch FSM: issue, wait for ack, or drain a request orphaned by a branch
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    rom_req_nxt_s  = rom_req_r;
    rom_addr_nxt_s = rom_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (branch_flag_i) begin
          fetch_pc_nxt_s = branch_target_i;
          rom_req_nxt_s  = 1'b0;
          state_nxt_s    = ST_IDLE;
        end else if (can_issue_s) begin
          rom_req_nxt_s  = 1'b1;
          rom_addr_nxt_s = fetch_pc_r;
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
          state_nxt_s    = ST_WAIT;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (branch_flag_i) begin
          fetch_pc_nxt_s = branch_target_i;
          if (rom_ack) begin
            rom_req_nxt_s = 1'b0;
            state_nxt_s   = ST_IDLE;
          end else begin
            // The request cannot be withdrawn; wait it out and drop the data.
            state_nxt_s   = ST_DISCARD;
          end
        end else if (rom_ack) begin
          if (can_issue_s) begin
            // Back-to-back reissue keeps a zero-wait memory at 1 word/cycle.
            rom_req_nxt_s  = 1'b1;
            rom_addr_nxt_s = fetch_pc_r;
            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
            state_nxt_s    = ST_WAIT;
          end else begin
            rom_req_nxt_s  = 1'b0;
            state_nxt_s    = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (branch_flag_i) begin
          fetch_pc_nxt_s = branch_target_i;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        if (rom_ack) begin
          rom_req_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s   = ST_DISCARD;
        end
      end
      default: begin
        fetch_pc_nxt_s = fetch_pc_r;
        rom_req_nxt_s  = 1'b0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  // FSM, fetch PC and memory request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      rom_req_r  <= 1'b0;
      rom_addr_r <= RESET_PC;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      rom_req_r  <= rom_req_nxt_s;
      rom_addr_r <= rom_addr_nxt_s;
    end
  end

  // FIFO pointers and occupancy; a branch empties the queue at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (branch_flag_i) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // FIFO storage: the returned word tagged with the address that fetched it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 32'h0000_0000;
        inst_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= rom_addr_r;
      inst_mem_r[wr_ptr_r] <= rom_data;
    end
  end

  // Present the FIFO head, or a zero PC / NOP bubble when nothing is valid
  always_comb begin
    if_valid = out_valid_s;
    if (out_valid_s) begin
      if_pc   = pc_mem_r[rd_ptr_r];
      if_inst = inst_mem_r[rd_ptr_r];
    end else begin
      if_pc   = 32'h0000_0000;
      if_inst = 32'h0000_0000;
    end
  end

  assign rom_req  = rom_req_r;
  assign rom_addr = rom_addr_r;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized traffic for if_fetch,
// checked every cycle against a transaction-level reference model
// (queue of fetched words, one outstanding-request flag, discard flag).

module tb_if_fetch;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          TB_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch #(.RESET_PC(RST_PC), .DEPTH(TB_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_req         (rom_req),
    .rom_addr        (rom_addr),
    .rom_ack         (rom_ack),
    .rom_data        (rom_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_fetch;
  logic        m_disc;

  // Memory responder state
  int          mem_lat;
  logic        mem_pend;
  int          mem_left;

  // Values observed in the most recent cycle
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_req   = 1'b0;
    m_addr  = RST_PC;
    m_fetch = RST_PC;
    m_disc  = 1'b0;
    mem_pend = 1'b0;
    mem_left = 0;
  endtask

  // One clock cycle: drive at negedge, check, advance the model, wait a cycle.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic ack, input logic [31:0] dat);
    logic        exp_v;
    logic [31:0] exp_pc, exp_inst;
    stall = st; branch_flag_i = br; branch_target_i = tgt;
    rom_ack = ack; rom_data = dat;
    #1;
    exp_v = (m_q.size() != 0) && !br;
    if (exp_v) begin
      exp_pc = m_q[0].pc; exp_inst = m_q[0].inst;
    end else begin
      exp_pc = 32'h0; exp_inst = 32'h0;
    end
    obs_req = rom_req; obs_addr = rom_addr; obs_valid = if_valid;
    obs_pc = if_pc; obs_inst = if_inst;
    check_eq("if_valid", {31'h0, if_valid}, {31'h0, exp_v});
    check_eq("if_pc", if_pc, exp_pc);
    check_eq("if_inst", if_inst, exp_inst);
    check_eq("rom_req", {31'h0, rom_req}, {31'h0, m_req});
    check_eq("rom_addr", rom_addr, m_addr);
    // Model the edge
    if (br) begin
      m_q.delete();
      m_fetch = tgt;
      if (m_req && !ack) begin
        m_disc = 1'b1;
      end else begin
        m_req = 1'b0; m_disc = 1'b0;
      end
    end else begin
      if (exp_v && !st) void'(m_q.pop_front());
      if (m_disc) begin
        if (ack) begin m_req = 1'b0; m_disc = 1'b0; end
      end else begin
        if (m_req && ack) m_q.push_back({m_addr, dat});
        if (!m_req || ack) begin
          if (m_q.size() < TB_DEPTH) begin
            m_req = 1'b1; m_addr = m_fetch; m_fetch = m_fetch + 32'd4;
          end else begin
            m_req = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Cycle with the memory responder supplying ack/data (latency mem_lat, <0 random).
  task automatic mem_cycle(input logic st, input logic br, input logic [31:0] tgt);
    logic a;
    a = 1'b0;
    if (rom_req && !mem_pend) begin
      mem_pend = 1'b1;
      mem_left = (mem_lat < 0) ? $urandom_range(0, 3) : mem_lat;
    end
    if (mem_pend) begin
      if (mem_left == 0) begin
        a = 1'b1; mem_pend = 1'b0;
      end else begin
        mem_left--;
      end
    end
    step(st, br, tgt, a, a ? mem_word(rom_addr) : 32'h0);
  endtask

  // Assert reset mid-cycle, check the reset state, release one edge later.
  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    rom_ack = 1'b0; rom_data = 32'h0;
    #1;
    check_eq("rst_req", {31'h0, rom_req}, 32'h0);
    check_eq("rst_addr", rom_addr, RST_PC);
    check_eq("rst_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_inst", if_inst, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        hit, found, bad;
    logic [31:0] next_pc;
    logic [31:0] seen[$];
    rst = 1'b0; stall = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    rom_ack = 1'b0; rom_data = 32'h0;
    model_reset();
    @(negedge clk);

    // T1: zero-wait memory, back-to-back fetch
    do_reset(); mem_lat = 0;
    mem_cycle(1'b0, 1'b0, 32'h0);
    check_eq("t1_idle_req", {31'h0, obs_req}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      check_eq("t1_addr", obs_addr, 32'(4 * k));
      if (k == 0) check_eq("t1_first_bubble", {31'h0, obs_valid}, 32'h0);
      else        check_eq("t1_pc", obs_pc, 32'(4 * (k - 1)));
    end

    // T2: stall fills the FIFO, then release resumes without skip or repeat
    do_reset(); mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
      mem_cycle(1'b1, 1'b0, 32'h0);
      if (i >= 3) begin
        check_eq("t2_req_drop", {31'h0, obs_req}, 32'h0);
        check_eq("t2_hold_pc", obs_pc, 32'h0);
      end
    end
    next_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (obs_valid) begin
        check_eq("t2_seq_pc", obs_pc, next_pc);
        next_pc = next_pc + 32'd4;
      end
    end

    // T3: latency 3, branch to 0x100 while waiting on 0x8
    do_reset(); mem_lat = 2; hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (rom_req && rom_addr == 32'h8) begin
        hit = 1'b1;
        mem_cycle(1'b0, 1'b1, 32'h100);
        check_eq("t3_bubble", {31'h0, obs_valid}, 32'h0);
      end else begin
        mem_cycle(1'b0, 1'b0, 32'h0);
      end
    end
    check_eq("t3_hit", {31'h0, hit}, 32'h1);
    mem_cycle(1'b0, 1'b0, 32'h0);
    check_eq("t3_discard_req", {31'h0, obs_req}, 32'h1);
    check_eq("t3_discard_addr", obs_addr, 32'h8);
    found = 1'b0; bad = 1'b0; hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (obs_valid && obs_pc == 32'h8) bad = 1'b1;
      if (!found && obs_req && obs_addr != 32'h8) begin
        found = 1'b1;
        check_eq("t3_next_req", obs_addr, 32'h100);
      end
      if (!hit && obs_valid) begin
        hit = 1'b1;
        check_eq("t3_first_pc", obs_pc, 32'h100);
      end
    end
    check_eq("t3_found", {30'h0, found, hit}, 32'h3);
    check_eq("t3_no_0x8", {31'h0, bad}, 32'h0);

    // T4: branch to 0x40 with ack for 0x10 and 0xC at the FIFO head
    do_reset(); mem_lat = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (rom_req && rom_addr == 32'h10) begin
        hit = 1'b1;
        check_eq("t4_head", if_pc, 32'hC);
        mem_cycle(1'b0, 1'b1, 32'h40);
        check_eq("t4_bubble", {31'h0, obs_valid}, 32'h0);
      end else begin
        mem_cycle(1'b0, 1'b0, 32'h0);
      end
    end
    check_eq("t4_hit", {31'h0, hit}, 32'h1);
    found = 1'b0; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (obs_valid && (obs_pc == 32'hC || obs_pc == 32'h10)) bad = 1'b1;
      if (!found && obs_req) begin
        found = 1'b1;
        check_eq("t4_next_req", obs_addr, 32'h40);
      end
    end
    check_eq("t4_found", {31'h0, found}, 32'h1);
    check_eq("t4_dropped", {31'h0, bad}, 32'h0);

    // T5: two branches while discarding; only the last target is fetched
    do_reset(); mem_lat = 3;
    mem_cycle(1'b0, 1'b0, 32'h0);
    mem_cycle(1'b0, 1'b1, 32'h200);
    check_eq("t5_wait_addr", obs_addr, 32'h0);
    mem_cycle(1'b0, 1'b1, 32'h300);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (!found && obs_req && obs_addr != 32'h0) begin
        found = 1'b1;
        check_eq("t5_next_req", obs_addr, 32'h300);
      end
    end
    check_eq("t5_found", {31'h0, found}, 32'h1);

    // T6: reset during WAIT, then a late ack after release is ignored
    do_reset(); mem_lat = 3;
    for (int i = 0; i < 3; i++) mem_cycle(1'b0, 1'b0, 32'h0);
    check_eq("t6_in_wait", {31'h0, rom_req}, 32'h1);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    mem_lat = 1;
    mem_cycle(1'b0, 1'b0, 32'h0);
    check_eq("t6_restart_req", {31'h0, obs_req}, 32'h1);
    check_eq("t6_restart_addr", obs_addr, RST_PC);
    check_eq("t6_no_late_word", {31'h0, obs_valid}, 32'h0);
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (!hit && obs_valid) begin
        hit = 1'b1;
        check_eq("t6_first_inst", obs_inst, mem_word(RST_PC));
      end
    end
    check_eq("t6_hit", {31'h0, hit}, 32'h1);

    // T7: address wrap at the top of the address space
    do_reset(); mem_lat = 0;
    mem_cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      mem_cycle(1'b0, 1'b0, 32'h0);
      if (obs_valid) seen.push_back(obs_pc);
    end
    check_eq("t7_count", {31'h0, (seen.size() >= 3)}, 32'h1);
    if (seen.size() >= 3) begin
      check_eq("t7_pc0", seen[0], 32'hFFFF_FFF8);
      check_eq("t7_pc1", seen[1], 32'hFFFF_FFFC);
      check_eq("t7_pc2", seen[2], 32'h0000_0000);
    end

    // T8: randomized stall / branch / latency / occasional reset
    do_reset(); mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        mem_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage feeding the IF/ID pipeline register. It holds the fetch PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. Returned words go into a small prefetch FIFO. The FIFO head is presented as if_pc/if_inst, with NOP bubbles when empty, stall hold, and branch redirect with discard of in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: prefetch FIFO entries; power of two, minimum 2.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  downstream cannot accept; the head is not consumed.
- branch_flag_i  input  1  one-cycle redirect request.
- branch_target_i  input  32  redirect address; word-aligned.
- rom_req  output  1  memory request, registered.
- rom_addr  output  32  request address, registered, stable while rom_req=1.
- rom_ack  input  1  one-cycle pulse; rom_data is valid in the same cycle.
- rom_data  input  32  instruction word.
- if_valid  output  1  FIFO head valid.
- if_pc  output  32  head PC, or 0 when not valid.
- if_inst  output  32  head instruction, or 0 (NOP) when not valid.

## Operation
- State: fetch_pc (next address to request), FIFO of {pc, inst} with a count, and an FSM with states IDLE, WAIT and DISCARD.
- Only one outstanding request at a time. The request cannot be aborted once issued.
- count_next is the FIFO occupancy after this edge's push and pop. A new request may issue only if count_next < DEPTH, so a returning word always has a slot.
- IDLE:
  - If the issue condition holds and there is no branch: rom_req<=1, rom_addr<=fetch_pc, fetch_pc<=fetch_pc+4, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, rom_ack=1, no branch:
  - Push {rom_addr, rom_data}.
  - If the issue condition holds, reissue at fetch_pc and stay in WAIT. This gives back-to-back fetch, 1 instruction per cycle with zero-wait memory.
  - Otherwise rom_req<=0 and go to IDLE.
- WAIT, rom_ack=0, no branch: hold rom_req and rom_addr.
- Branch (branch_flag_i=1), in any state:
  - FIFO is cleared and fetch_pc<=branch_target_i. Any rom_ack in the same cycle is dropped, not pushed.
  - WAIT without ack goes to DISCARD, keeping rom_req and rom_addr held.
  - IDLE, or WAIT with ack, goes to IDLE with rom_req<=0.
- DISCARD:
  - On rom_ack, the data is dropped, rom_req<=0, go to IDLE.
  - A further branch in DISCARD updates fetch_pc and stays in DISCARD.
- Output and pop:
  - if_valid = FIFO not empty and branch_flag_i=0. if_pc/if_inst follow the head when if_valid=1, else 0.
  - Pop at an edge when if_valid=1 and stall=0.
  - When stall=1, outputs hold the same head.
- Delay-slot semantics are the branch unit's responsibility: it asserts branch_flag_i only after the delay-slot instruction has been consumed.
- fetch_pc and addresses wrap modulo 2^32; 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values:
  - rom_req=0, rom_addr=RESET_PC, fetch_pc=RESET_PC.
  - FSM in IDLE, FIFO empty.
  - if_valid=0, if_pc=0, if_inst=0.
- Reset assertion mid-transaction aborts immediately. Any late rom_ack after reset release, while in IDLE, is ignored.
- rom_req is first asserted by the first edge after reset release, at address RESET_PC.
- A word sampled with rom_ack at edge N appears on if_* after edge N, and the downstream register can capture it at edge N+1.
- A branch at edge N gives bubbles from the branch cycle until the first target word returns. The first target request is issued at edge N+1 at the earliest.
- Simultaneous push, pop and issue in one edge are all legal; count changes by push minus pop.

## Test plan
- Reset then zero-wait ack (ack in the first rom_req cycle) -> rom_addr 0,4,8,12 on consecutive cycles; if_pc 0,4,8 one cycle behind; if_valid=0 in the first cycle.
- stall=1 held, memory acks within 1 cycle -> FIFO fills with 2 entries and rom_req drops; if_pc holds 0. Release stall -> fetch resumes with no address skipped or repeated.
- Memory latency 3 cycles, branch to 0x100 while waiting on address 0x8 -> ack for 0x8 dropped, FSM in DISCARD; next request is 0x100; if_pc shows 0x100 and never 0x8.
- Branch to 0x40 in the same cycle as an ack for 0x10, with the FIFO holding 0xC -> if_valid=0 that cycle; 0xC and 0x10 never presented; next request 0x40.
- Two branches in DISCARD (0x200, then 0x300) -> only 0x300 is requested after the ack.
- rst pulled low during WAIT -> rom_req=0 and if_* = 0 immediately; after release, fetch restarts at RESET_PC; a late ack is ignored.
